// File: rtl/conv_bram_responder.sv
// -----------------------------------------------------------------------------
// conv_bram_responder
//
// Memory-side responder for one native BRAM port of a conv engine (image,
// kernel or output port). Holds DEPTH x 32-bit words and answers the engine
// with a fixed one-cycle, read-first read latency. A host load/readback port
// (valid/ready request, one-cycle ack) preloads data and reads results back.
// Identical instances serve engine ports A, B and C.
//
// Ports
//   clk      : clock (engines drive their BRAM clock from this same clock)
//   rst_n    : synchronous active-low reset
//   p_rst    : engine output-register reset, synchronous active-high
//   p_en     : engine port enable
//   p_addr   : engine byte address (word aligned)
//   p_din    : engine write data
//   p_we     : engine byte write enables, bit i writes bits [8i+7:8i]
//   p_dout   : engine read data, registered
//   h_valid  : host request valid
//   h_ready  : host request accepted when h_valid & h_ready
//   h_we     : host request type, 1 = write, 0 = read
//   h_addr   : host word index
//   h_wdata  : host write data (full word)
//   h_ack    : one-cycle pulse when a host request completes
//   h_rdata  : host read data, valid with h_ack on reads
//   err      : sticky flag, engine access to an out-of-range/unaligned address
//   err_clr  : synchronous clear for err
//   wr_cnt   : saturating count of in-range engine write cycles
// -----------------------------------------------------------------------------
module conv_bram_responder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_rst,
    input  logic              p_en,
    input  logic [31:0]       p_addr,
    input  logic [31:0]       p_din,
    input  logic [3:0]        p_we,
    output logic [31:0]       p_dout,
    input  logic              h_valid,
    output logic              h_ready,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [31:0]       h_wdata,
    output logic              h_ack,
    output logic [31:0]       h_rdata,
    output logic              err,
    input  logic              err_clr,
    output logic [15:0]       wr_cnt
);

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_t;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       p_dout_q;
    logic [31:0]       h_rdata_q;
    logic              h_ack_q;
    logic              err_q;
    logic              err_d;
    logic [15:0]       wr_cnt_q;
    logic [15:0]       wr_cnt_d;
    state_t            state_q;

    logic              in_range;
    logic [ADDR_W-1:0] p_idx;
    logic              eng_acc;
    logic              eng_wr;
    logic              eng_bad;
    logic              host_acc;

    // Address decode: only aligned byte addresses inside the array are valid;
    // anything else (including aliases above the top word) is an error.
    assign in_range = (p_addr[1:0] == 2'b00) && (p_addr[31:ADDR_W+2] == '0);
    assign p_idx    = p_addr[ADDR_W+1:2];
    assign eng_acc  = p_en && in_range;
    assign eng_wr   = eng_acc && (|p_we);
    assign eng_bad  = p_en && !in_range;

    // The engine owns the array whenever p_en is high, so host and engine
    // never touch memory in the same cycle. rst_n is folded in so the host
    // sees h_ready=0 while reset is held.
    assign h_ready  = (state_q == ST_IDLE) && !p_en && rst_n;
    assign host_acc = h_ready && h_valid;

    // Memory array: no reset (contents survive rst_n). Engine byte writes use
    // per-lane enables; the host always writes a full word.
    always_ff @(posedge clk) begin
        if (eng_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (p_we[b]) begin
                    mem_q[p_idx][8*b +: 8] <= p_din[8*b +: 8];
                end
            end
        end else if (host_acc && h_we) begin
            mem_q[h_addr] <= h_wdata;
        end
    end

    // Engine read register: read-first, so the old word is returned even when
    // the same cycle writes it. p_rst wins over the read but not the write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_dout_q <= '0;
        end else if (p_rst) begin
            p_dout_q <= '0;
        end else if (eng_acc) begin
            p_dout_q <= mem_q[p_idx];
        end else if (eng_bad) begin
            p_dout_q <= '0;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        err_d = err_q;
        if (eng_bad) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (eng_wr && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q    <= 1'b0;
            wr_cnt_q <= '0;
        end else begin
            err_q    <= err_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Host FSM. The read word is captured at acceptance, so engine activity
    // during the RESP cycle cannot disturb h_rdata. h_rdata is left untouched
    // by writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            h_ack_q   <= 1'b0;
            h_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    h_ack_q <= 1'b0;
                    if (host_acc) begin
                        state_q <= ST_RESP;
                        h_ack_q <= 1'b1;
                        if (!h_we) begin
                            h_rdata_q <= mem_q[h_addr];
                        end
                    end
                end
                ST_RESP: begin
                    h_ack_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    h_ack_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign p_dout  = p_dout_q;
    assign h_ack   = h_ack_q;
    assign h_rdata = h_rdata_q;
    assign err     = err_q;
    assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_conv_bram_responder.sv
// -----------------------------------------------------------------------------
// tb_conv_bram_responder
//
// Self-checking bench: directed scenarios followed by a randomized mix of
// engine and host transactions. A transaction-level model (word array plus
// expected p_dout / err / wr_cnt) supplies every expected value.
// -----------------------------------------------------------------------------
module tb_conv_bram_responder;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              p_rst;
    logic              p_en;
    logic [31:0]       p_addr;
    logic [31:0]       p_din;
    logic [3:0]        p_we;
    logic [31:0]       p_dout;
    logic              h_valid;
    logic              h_ready;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [31:0]       h_wdata;
    logic              h_ack;
    logic [31:0]       h_rdata;
    logic              err;
    logic              err_clr;
    logic [15:0]       wr_cnt;

    always #5 clk = ~clk;

    conv_bram_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .p_rst   (p_rst),
        .p_en    (p_en),
        .p_addr  (p_addr),
        .p_din   (p_din),
        .p_we    (p_we),
        .p_dout  (p_dout),
        .h_valid (h_valid),
        .h_ready (h_ready),
        .h_we    (h_we),
        .h_addr  (h_addr),
        .h_wdata (h_wdata),
        .h_ack   (h_ack),
        .h_rdata (h_rdata),
        .err     (err),
        .err_clr (err_clr),
        .wr_cnt  (wr_cnt)
    );

    int          checks   = 0;
    int          failures = 0;

    // Reference model state
    logic [31:0] mem_m [DEPTH];
    logic [31:0] dout_m;
    logic        err_m;
    int          cnt_m;
    logic [31:0] rdata_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One engine cycle with p_en=1, checked one cycle later.
    task automatic eng(input logic [31:0] addr, input logic [31:0] din,
                       input logic [3:0] we, input logic prst, input logic clr);
        bit inr;
        int idx;
        p_en    = 1'b1;
        p_addr  = addr;
        p_din   = din;
        p_we    = we;
        p_rst   = prst;
        err_clr = clr;
        inr = (addr % 4 == 0) && (addr < DEPTH * 4);
        if (inr) begin
            idx    = int'(addr / 4);
            dout_m = mem_m[idx];
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem_m[idx][8*b +: 8] = din[8*b +: 8];
            end
            if (we != 4'b0 && cnt_m < 65535) cnt_m++;
            if (clr) err_m = 1'b0;
        end else begin
            dout_m = 32'h0;
            err_m  = 1'b1;
        end
        if (prst) dout_m = 32'h0;
        step();
        p_en    = 1'b0;
        p_we    = 4'b0;
        p_rst   = 1'b0;
        err_clr = 1'b0;
        $display("eng addr=%h din=%h we=%b prst=%0d clr=%0d dout=%h err=%0d cnt=%0d",
                 addr, din, we, prst, clr, p_dout, err, wr_cnt);
        check("eng_dout", p_dout, dout_m);
        check("eng_err", err, err_m);
        check("eng_wr_cnt", wr_cnt, cnt_m);
    endtask

    // A cycle with the engine idle; optional p_rst / err_clr.
    task automatic idle(input logic prst, input logic clr);
        p_rst   = prst;
        err_clr = clr;
        if (prst) dout_m = 32'h0;
        if (clr)  err_m  = 1'b0;
        step();
        p_rst   = 1'b0;
        err_clr = 1'b0;
        $display("idle prst=%0d clr=%0d dout=%h err=%0d", prst, clr, p_dout, err);
        check("idle_dout", p_dout, dout_m);
        check("idle_err", err, err_m);
    endtask

    // Full host transfer with a bounded wait for h_ready.
    task automatic host(input bit we, input int a, input logic [31:0] wd);
        int waited;
        waited  = 0;
        h_valid = 1'b1;
        h_we    = we;
        h_addr  = a[ADDR_W-1:0];
        h_wdata = wd;
        #1;
        while (!h_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!h_ready) begin
            check("host_ready_timeout", h_ready, 1'b1);
            h_valid = 1'b0;
            return;
        end
        step();
        h_valid = 1'b0;
        if (we) mem_m[a] = wd;
        else    rdata_m  = mem_m[a];
        $display("host we=%0d addr=%0d wdata=%h ack=%0d rdata=%h", we, a, wd, h_ack, h_rdata);
        check("host_ack", h_ack, 1'b1);
        check("host_ready_resp", h_ready, 1'b0);
        if (!we) check("host_rdata", h_rdata, rdata_m);
        step();
        check("host_ack_done", h_ack, 1'b0);
        check("host_dout_hold", p_dout, dout_m);
    endtask

    initial begin
        int r;
        int idx;
        logic [31:0] a;

        rst_n = 1'b0; p_rst = 1'b0; p_en = 1'b0; p_addr = '0; p_din = '0; p_we = '0;
        h_valid = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0; err_clr = 1'b0;
        dout_m = 32'h0; err_m = 1'b0; cnt_m = 0; rdata_m = 32'h0;

        // Reset state
        step(); step(); step();
        check("rst_dout", p_dout, 32'h0);
        check("rst_ready", h_ready, 1'b0);
        check("rst_ack", h_ack, 1'b0);
        check("rst_rdata", h_rdata, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_wr_cnt", wr_cnt, 16'h0);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", h_ready, 1'b1);

        // Preload: word 1 = 0, word 2 = 5, others random
        for (int i = 0; i < DEPTH; i++) begin
            host(1'b1, i, (i == 1) ? 32'h0 : (i == 2) ? 32'h5 : $urandom);
        end

        // Host write then engine read of the same word
        host(1'b1, 3, 32'h11223344);
        eng(32'h0C, 32'h0, 4'b0000, 1'b0, 1'b0);
        check("t1_dout", p_dout, 32'h11223344);

        // Byte-enable write then host readback
        eng(32'h04, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0);
        host(1'b0, 1, 32'h0);
        check("t2_rdata", h_rdata, 32'h00BB00DD);
        check("t2_wr_cnt", wr_cnt, 16'd1);

        // Read-first on same-cycle read+write
        eng(32'h08, 32'h9, 4'b1111, 1'b0, 1'b0);
        check("t3_old", p_dout, 32'h5);
        eng(32'h08, 32'h0, 4'b0000, 1'b0, 1'b0);
        check("t3_new", p_dout, 32'h9);

        // Host starved by 5 engine cycles, accepted on the first free cycle
        h_valid = 1'b1; h_we = 1'b0; h_addr = 4'd3; h_wdata = '0;
        for (int i = 0; i < 5; i++) begin
            p_en = 1'b1; p_addr = 32'h0C; p_we = 4'b0;
            #1;
            check("starve_ready", h_ready, 1'b0);
            dout_m = mem_m[3];
            step();
        end
        p_en = 1'b0;
        #1;
        check("starve_free_ready", h_ready, 1'b1);
        step();
        h_valid = 1'b0;
        $display("host starved read addr=3 ack=%0d rdata=%h", h_ack, h_rdata);
        check("starve_ack", h_ack, 1'b1);
        check("starve_rdata", h_rdata, 32'h11223344);
        step();
        check("starve_ack_done", h_ack, 1'b0);
        check("starve_dout", p_dout, dout_m);

        // Out-of-range access, memory untouched, then clear
        eng(32'h40, 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b0);
        check("oor_err", err, 1'b1);
        check("oor_dout", p_dout, 32'h0);
        host(1'b0, 0, 32'h0);
        idle(1'b0, 1'b1);
        check("oor_clr", err, 1'b0);
        // Clear and new error together keep err set
        eng(32'h06, 32'h12345678, 4'b1111, 1'b0, 1'b1);
        check("clr_vs_err", err, 1'b1);
        idle(1'b0, 1'b1);

        // Randomized mix
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            idx = $urandom_range(0, DEPTH - 1);
            if (r <= 3) begin
                eng(idx * 4, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            end else if (r == 4) begin
                if ($urandom_range(0, 1) == 1) a = 32'(idx * 4 + $urandom_range(1, 3));
                else                           a = $urandom | 32'h40;
                eng(a, $urandom, 4'($urandom_range(0, 15)), 1'b0, $urandom_range(0, 3) == 0);
            end else if (r <= 7) begin
                host($urandom_range(0, 1) == 1, idx, $urandom);
            end else if (r == 8) begin
                idle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            end else begin
                eng(idx * 4, $urandom, 4'b0000, 1'b0, 1'b0);
            end
        end

        // Reset while in RESP of a host write: ack dropped, write retained
        eng(32'h0C, 32'h0, 4'b0000, 1'b0, 1'b0);
        h_valid = 1'b1; h_we = 1'b1; h_addr = 4'd7; h_wdata = 32'hCAFEF00D;
        #1;
        check("mid_ready", h_ready, 1'b1);
        step();
        h_valid = 1'b0;
        rst_n = 1'b0;
        mem_m[7] = 32'hCAFEF00D;
        step();
        $display("reset during RESP ack=%0d dout=%h rdata=%h", h_ack, p_dout, h_rdata);
        check("mid_ack", h_ack, 1'b0);
        check("mid_dout", p_dout, 32'h0);
        check("mid_rdata", h_rdata, 32'h0);
        check("mid_err", err, 1'b0);
        check("mid_wr_cnt", wr_cnt, 16'h0);
        rst_n = 1'b1;
        dout_m = 32'h0; err_m = 1'b0; cnt_m = 0;
        step();
        check("mid_ack_after", h_ack, 1'b0);
        host(1'b0, 7, 32'h0);
        check("mid_keep", h_rdata, 32'hCAFEF00D);
        host(1'b0, 3, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
